hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage MIPS CPU. It sits beside the forwarding unit in the ID stage. It detects load-use hazards and generates the PC, IF/ID and ID/EX write/flush controls. It squashes the younger instructions on a taken branch resolved in EX. It also sequences the multi-cycle multiply/divide unit (MDU), tracking its busy window and stalling dependent HI/LO reads and structurally conflicting MDU ops.

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Load-use / branch hazard control and multi-cycle MDU sequencing
//            for the 5-stage MIPS pipeline (ID-stage companion of forwarding).
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_use_rt,
  input  logic       ID_EX_memread,
  input  logic [4:0] ID_EX_Rt,
  input  logic       ID_mdu,
  input  logic       ID_hilo_rd,
  input  logic       EX_branch_taken,
  output logic       pc_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       mdu_start,
  output logic       mdu_busy,
  output logic       hilo_we
);

  localparam logic [CNT_W-1:0] C_MDU_LAT = CNT_W'(MDU_LAT);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load_use;
  logic             w_stall;
  logic             w_last;

  // Busy is a pure decode of the registered state, never of the inputs.
  assign mdu_busy = (r_state == ST_BUSY);

  // Final cycle of an MDU operation: HI/LO get written here.
  assign w_last = (r_state == ST_BUSY) && (r_cnt == C_CNT_ONE);

  // Load-use hazard; $0 is never a real dependency.
  assign w_load_use = ID_EX_memread && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == ID_Rs) || (ID_use_rt && (ID_EX_Rt == ID_Rt)));

  // HI/LO readers and new MDU ops must wait while an op is in flight.
  assign w_stall = w_load_use || (mdu_busy && (ID_hilo_rd || ID_mdu));

  // State and latency counter register; reset aborts any in-flight op.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pipeline controls: branch squash beats stall, stall beats normal flow.
  always_comb begin
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    mdu_start   = 1'b0;
    hilo_we     = 1'b0;
    if (!rst_i) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else begin
      hilo_we = w_last;
      if (EX_branch_taken) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (w_stall) begin
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
      end else begin
        mdu_start = ID_mdu;
      end
    end
  end

  // MDU sequencer next state; a branch never cancels an older MDU op.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (mdu_start) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = C_MDU_LAT;
        end
      end
      ST_BUSY: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
